// File: rtl/random_point_gen_if.sv
// Request/candidate/result bundle between the snake game logic (master) and the food generator (slave).
// cand_hit is driven combinationally by the game from cand_x/cand_y while the generator is in CHECK.
interface random_point_gen_if #(
    parameter int COORD_W = 10
);
    logic               req;
    logic               cand_hit;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic [COORD_W-1:0] rand_x;
    logic [COORD_W-1:0] rand_y;
    logic               valid;
    logic               forced;
    logic               busy;

    modport master (
        output req, cand_hit,
        input  cand_x, cand_y, rand_x, rand_y, valid, forced, busy
    );

    modport slave (
        input  req, cand_hit,
        output cand_x, cand_y, rand_x, rand_y, valid, forced, busy
    );
endinterface

// File: rtl/random_point_gen.sv
// Food position generator: free-running LFSR mapped into a cell window, with bounded redraw on occupancy hit.
// Each draw takes 2 cycles (DRAW, CHECK); req is only honoured in IDLE and never queued.
module random_point_gen #(
    parameter int          COORD_W   = 10,
    parameter int          CELL      = 10,
    parameter int          X_MIN     = 3,
    parameter int          X_MAX     = 61,
    parameter int          Y_MIN     = 3,
    parameter int          Y_MAX     = 45,
    parameter int          LFSR_W    = 16,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic                 clk_vga,
    input  logic                 rst,
    random_point_gen_if.slave    bus
);
    localparam int SX = X_MAX - X_MIN + 1;
    localparam int SY = Y_MAX - Y_MIN + 1;
    localparam int XB = (SX <= 2) ? 1 : $clog2(SX);
    localparam int YB = (SY <= 2) ? 1 : $clog2(SY);
    localparam int TW = (MAX_TRIES <= 2) ? 1 : $clog2(MAX_TRIES);

    localparam logic [TW-1:0]      LAST_TRY = TW'(MAX_TRIES - 1);
    localparam logic [LFSR_W-1:0]  SEED_EFF = (SEED == 16'h0) ? LFSR_W'(1) : LFSR_W'(SEED);
    localparam logic [COORD_W-1:0] X0_PX    = COORD_W'(X_MIN * CELL);
    localparam logic [COORD_W-1:0] Y0_PX    = COORD_W'(Y_MIN * CELL);

    if (LFSR_W != 16) begin : g_bad_lfsr
        $error("random_point_gen: only a 16-bit LFSR is supported");
    end
    if (X_MIN > X_MAX || Y_MIN > Y_MAX || X_MIN < 0 || Y_MIN < 0) begin : g_bad_window
        $error("random_point_gen: empty or negative playfield window");
    end
    if (X_MAX * CELL >= (1 << COORD_W) || Y_MAX * CELL >= (1 << COORD_W)) begin : g_bad_coord
        $error("random_point_gen: playfield does not fit in COORD_W bits");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("random_point_gen: MAX_TRIES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, DRAW, CHECK} state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [TW-1:0]      tries_q, tries_d;
    logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [COORD_W-1:0] rand_x_q, rand_x_d, rand_y_q, rand_y_d;
    logic               valid_q, valid_d, forced_q, forced_d;
    logic               busy;

    logic [XB-1:0]      raw_x;
    logic [YB-1:0]      raw_y;
    logic [COORD_W-1:0] off_x, off_y, map_x, map_y;

    assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign raw_x  = lfsr_q[XB-1:0];
    assign raw_y  = lfsr_q[LFSR_W-1 -: YB];

    // Raw values are below twice the span, so one conditional subtract folds them into range.
    always_comb begin
        off_x = COORD_W'(raw_x);
        off_y = COORD_W'(raw_y);
        if (off_x >= COORD_W'(SX)) off_x = off_x - COORD_W'(SX);
        if (off_y >= COORD_W'(SY)) off_y = off_y - COORD_W'(SY);
        map_x = (COORD_W'(X_MIN) + off_x) * COORD_W'(CELL);
        map_y = (COORD_W'(Y_MIN) + off_y) * COORD_W'(CELL);
    end

    always_ff @(posedge clk_vga) begin
        if (!rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_EFF;
            tries_q  <= '0;
            cand_x_q <= X0_PX;
            cand_y_q <= Y0_PX;
            rand_x_q <= X0_PX;
            rand_y_q <= Y0_PX;
            valid_q  <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tries_q  <= tries_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            rand_x_q <= rand_x_d;
            rand_y_q <= rand_y_d;
            valid_q  <= valid_d;
            forced_q <= forced_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        rand_x_d = rand_x_q;
        rand_y_d = rand_y_q;
        valid_d  = 1'b0;
        forced_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                cand_x_d = map_x;
                cand_y_d = map_y;
                state_d  = CHECK;
            end
            CHECK: begin
                if (bus.cand_hit && tries_q != LAST_TRY) begin
                    tries_d = tries_q + 1'b1;
                    state_d = DRAW;
                end else begin
                    rand_x_d = cand_x_q;
                    rand_y_d = cand_y_q;
                    valid_d  = 1'b1;
                    forced_d = bus.cand_hit;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    assign bus.cand_x = cand_x_q;
    assign bus.cand_y = cand_y_q;
    assign bus.rand_x = rand_x_q;
    assign bus.rand_y = rand_y_q;
    assign bus.valid  = valid_q;
    assign bus.forced = forced_q;
    assign bus.busy   = busy;
endmodule

// File: tb/tb_random_point_gen.sv
// Bench for random_point_gen: a default build plus a one-column window build with SEED=0.
module tb_random_point_gen;
    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       f;
    } exp_t;

    logic clk_vga = 1'b0;
    logic rst     = 1'b0;
    always #5 clk_vga = ~clk_vga;

    random_point_gen_if #(.COORD_W(10)) bus_a ();
    random_point_gen_if #(.COORD_W(10)) bus_b ();

    random_point_gen #(
        .COORD_W(10), .CELL(10), .X_MIN(3), .X_MAX(61), .Y_MIN(3), .Y_MAX(45),
        .LFSR_W(16), .SEED(16'hACE1), .MAX_TRIES(8)
    ) u_a (
        .clk_vga(clk_vga), .rst(rst), .bus(bus_a)
    );

    random_point_gen #(
        .COORD_W(10), .CELL(10), .X_MIN(5), .X_MAX(5), .Y_MIN(0), .Y_MAX(1),
        .LFSR_W(16), .SEED(16'h0000), .MAX_TRIES(8)
    ) u_b (
        .clk_vga(clk_vga), .rst(rst), .bus(bus_b)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] m_a, m_b;

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] l, input int n);
        logic [15:0] v;
        v = l;
        for (int i = 0; i < n; i++) v = nxt(v);
        return v;
    endfunction

    function automatic logic [9:0] ax(input logic [15:0] l);
        int r;
        r = int'(l[5:0]);
        if (r >= 59) r -= 59;
        return 10'((3 + r) * 10);
    endfunction

    function automatic logic [9:0] ay(input logic [15:0] l);
        int r;
        r = int'(l[15:10]);
        if (r >= 43) r -= 43;
        return 10'((3 + r) * 10);
    endfunction

    function automatic logic [9:0] by(input logic [15:0] l);
        return l[15] ? 10'd10 : 10'd0;
    endfunction

    // Reference LFSRs track the free-running DUT registers from reset.
    always @(posedge clk_vga) begin
        if (!rst) begin
            m_a <= 16'hACE1;
            m_b <= 16'h0001;
        end else begin
            m_a <= nxt(m_a);
            m_b <= nxt(m_b);
        end
    end

    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (bus_a.rand_x !== 10'd30 || bus_a.rand_y !== 10'd30) begin
            errors++;
            $display("FAIL reset_rand_a got %0d/%0d want 30/30", bus_a.rand_x, bus_a.rand_y);
        end
        checks++;
        if (bus_a.cand_x !== 10'd30 || bus_a.cand_y !== 10'd30) begin
            errors++;
            $display("FAIL reset_cand_a got %0d/%0d want 30/30", bus_a.cand_x, bus_a.cand_y);
        end
        checks++;
        if ({bus_a.valid, bus_a.forced, bus_a.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags_a got v%b f%b b%b want 000", bus_a.valid, bus_a.forced, bus_a.busy);
        end
        checks++;
        if (u_a.lfsr_q !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_lfsr_a got %h want ace1", u_a.lfsr_q);
        end
        checks++;
        if (u_b.lfsr_q !== 16'h0001) begin
            errors++;
            $display("FAIL reset_lfsr_seed0 got %h want 0001", u_b.lfsr_q);
        end
        checks++;
        if (bus_b.rand_x !== 10'd50 || bus_b.rand_y !== 10'd0 || bus_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_b got %0d/%0d busy %b want 50/0 busy 0", bus_b.rand_x, bus_b.rand_y, bus_b.busy);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_latency();
        exp_t e, g;
        bus_a.cand_hit = 1'b0;
        bus_a.req = 1'b1;
        step();
        bus_a.req = 1'b0;
        e = '{x: ax(m_a), y: ay(m_a), f: 1'b0};
        sb.push_back(e);
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_n1 busy %b valid %b want 1 0", bus_a.busy, bus_a.valid);
        end
        step();
        checks++;
        if (bus_a.cand_x !== e.x || bus_a.cand_y !== e.y || bus_a.valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cand got %0d/%0d v%b want %0d/%0d v0", bus_a.cand_x, bus_a.cand_y, bus_a.valid, e.x, e.y);
        end
        step();
        checks++;
        if (bus_a.valid !== 1'b1 || bus_a.forced !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_valid v%b f%b b%b want 1 0 0", bus_a.valid, bus_a.forced, bus_a.busy);
        end
        if (bus_a.valid === 1'b1 && sb.size() > 0) begin
            g = sb.pop_front();
            checks++;
            if (bus_a.rand_x !== g.x || bus_a.rand_y !== g.y || bus_a.cand_x !== g.x || bus_a.cand_y !== g.y) begin
                errors++;
                $display("FAIL lat_rand got %0d/%0d want %0d/%0d", bus_a.rand_x, bus_a.rand_y, g.x, g.y);
            end
        end
        sb.delete();
        step();
        checks++;
        if (bus_a.valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_pulse valid %b want 0", bus_a.valid);
        end
    endtask

    task automatic test_range_sweep();
        bit   hx[64];
        bit   hy[64];
        int   nx, ny, gap;
        exp_t g;
        foreach (hx[i]) hx[i] = 1'b0;
        foreach (hy[i]) hy[i] = 1'b0;
        bus_a.cand_hit = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            bus_a.req = 1'b1;
            step();
            bus_a.req = 1'b0;
            sb.push_back('{x: ax(m_a), y: ay(m_a), f: 1'b0});
            for (int c = 0; c < 6 && bus_a.valid !== 1'b1; c++) step();
            checks++;
            if (bus_a.valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_timeout req %0d", n);
                sb.delete();
            end else begin
                g = sb.pop_front();
                checks++;
                if (bus_a.rand_x !== g.x || bus_a.rand_y !== g.y || bus_a.forced !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_value req %0d got %0d/%0d f%b want %0d/%0d f0",
                             n, bus_a.rand_x, bus_a.rand_y, bus_a.forced, g.x, g.y);
                end
                checks++;
                if (bus_a.rand_x % 10 != 0 || bus_a.rand_x < 30 || bus_a.rand_x > 610 ||
                    bus_a.rand_y % 10 != 0 || bus_a.rand_y < 30 || bus_a.rand_y > 450) begin
                    errors++;
                    $display("FAIL sweep_range req %0d got %0d/%0d", n, bus_a.rand_x, bus_a.rand_y);
                end else begin
                    hx[bus_a.rand_x / 10] = 1'b1;
                    hy[bus_a.rand_y / 10] = 1'b1;
                end
            end
        end
        nx = 0;
        ny = 0;
        foreach (hx[i]) if (hx[i]) nx++;
        foreach (hy[i]) if (hy[i]) ny++;
        checks++;
        if (nx != 59) begin
            errors++;
            $display("FAIL sweep_cover_x got %0d cells want 59", nx);
        end
        checks++;
        if (ny != 43) begin
            errors++;
            $display("FAIL sweep_cover_y got %0d cells want 43", ny);
        end
    endtask

    task automatic test_retry();
        logic [15:0] l;
        logic [9:0]  dx[3];
        logic [9:0]  dy[3];
        exp_t        g;
        step();
        bus_a.cand_hit = 1'b1;
        bus_a.req = 1'b1;
        step();
        bus_a.req = 1'b0;
        l = m_a;
        for (int k = 0; k < 3; k++) begin
            dx[k] = ax(adv(l, 2 * k));
            dy[k] = ay(adv(l, 2 * k));
        end
        sb.push_back('{x: dx[2], y: dy[2], f: 1'b0});
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus_a.cand_x !== dx[k] || bus_a.cand_y !== dy[k] || bus_a.valid !== 1'b0) begin
                errors++;
                $display("FAIL retry_cand%0d got %0d/%0d v%b want %0d/%0d v0",
                         k, bus_a.cand_x, bus_a.cand_y, bus_a.valid, dx[k], dy[k]);
            end
            step();
            if (k == 1) bus_a.cand_hit = 1'b0;
            if (k < 2) begin
                checks++;
                if (bus_a.valid !== 1'b0 || bus_a.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL retry_busy%0d v%b b%b want 0 1", k, bus_a.valid, bus_a.busy);
                end
            end
        end
        checks++;
        if (bus_a.valid !== 1'b1 || bus_a.forced !== 1'b0) begin
            errors++;
            $display("FAIL retry_valid v%b f%b want 1 0 at N+7", bus_a.valid, bus_a.forced);
            sb.delete();
        end else begin
            g = sb.pop_front();
            checks++;
            if (bus_a.rand_x !== g.x || bus_a.rand_y !== g.y) begin
                errors++;
                $display("FAIL retry_rand got %0d/%0d want %0d/%0d", bus_a.rand_x, bus_a.rand_y, g.x, g.y);
            end
        end
        step();
    endtask

    task automatic test_exhaust();
        int   pulses, at;
        exp_t g;
        bus_a.cand_hit = 1'b1;
        bus_a.req = 1'b1;
        step();
        bus_a.req = 1'b0;
        sb.push_back('{x: ax(adv(m_a, 14)), y: ay(adv(m_a, 14)), f: 1'b1});
        pulses = 0;
        at = -1;
        for (int i = 1; i <= 22; i++) begin
            step();
            bus_a.req = (i == 4);
            if (bus_a.valid === 1'b1) begin
                pulses++;
                at = i;
                checks++;
                if (bus_a.forced !== 1'b1) begin
                    errors++;
                    $display("FAIL exhaust_forced got %b want 1", bus_a.forced);
                end
                if (sb.size() > 0) begin
                    g = sb.pop_front();
                    checks++;
                    if (bus_a.rand_x !== g.x || bus_a.rand_y !== g.y) begin
                        errors++;
                        $display("FAIL exhaust_rand got %0d/%0d want %0d/%0d", bus_a.rand_x, bus_a.rand_y, g.x, g.y);
                    end
                end
            end
        end
        bus_a.req = 1'b0;
        bus_a.cand_hit = 1'b0;
        checks++;
        if (pulses != 1 || at != 16) begin
            errors++;
            $display("FAIL exhaust_pulses got %0d at +%0d want 1 at +16 (cycle N+17)", pulses, at);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t g;
        bus_a.cand_hit = 1'b0;
        bus_a.req = 1'b1;
        step();
        sb.push_back('{x: ax(m_a), y: ay(m_a), f: 1'b0});
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4 && bus_a.valid !== 1'b1; c++) step();
            checks++;
            if (bus_a.valid !== 1'b1 || bus_a.busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_valid%0d v%b b%b want 1 0", p, bus_a.valid, bus_a.busy);
                sb.delete();
            end else begin
                g = sb.pop_front();
                checks++;
                if (bus_a.rand_x !== g.x || bus_a.rand_y !== g.y) begin
                    errors++;
                    $display("FAIL b2b_rand%0d got %0d/%0d want %0d/%0d", p, bus_a.rand_x, bus_a.rand_y, g.x, g.y);
                end
            end
            if (p == 3) bus_a.req = 1'b0;
            step();
            if (p < 3) sb.push_back('{x: ax(m_a), y: ay(m_a), f: 1'b0});
        end
        sb.delete();
    endtask

    task automatic test_degenerate();
        exp_t g;
        bus_b.cand_hit = 1'b0;
        for (int n = 0; n < 24; n++) begin
            bus_b.req = 1'b1;
            step();
            bus_b.req = 1'b0;
            sb.push_back('{x: 10'd50, y: by(m_b), f: 1'b0});
            for (int c = 0; c < 4 && bus_b.valid !== 1'b1; c++) step();
            checks++;
            if (bus_b.valid !== 1'b1) begin
                errors++;
                $display("FAIL degen_timeout req %0d", n);
                sb.delete();
            end else begin
                g = sb.pop_front();
                checks++;
                if (bus_b.rand_x !== g.x || bus_b.rand_y !== g.y) begin
                    errors++;
                    $display("FAIL degen_rand req %0d got %0d/%0d want %0d/%0d", n, bus_b.rand_x, bus_b.rand_y, g.x, g.y);
                end
            end
            step();
        end
        bus_b.req = 1'b1;
        step();
        bus_b.req = 1'b0;
        step();
        checks++;
        if (bus_b.busy !== 1'b1) begin
            errors++;
            $display("FAIL degen_check_busy got %b want 1", bus_b.busy);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus_b.valid !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.rand_x !== 10'd50 || bus_b.rand_y !== 10'd0 ||
            bus_b.cand_x !== 10'd50 || bus_b.cand_y !== 10'd0) begin
            errors++;
            $display("FAIL degen_reset v%b b%b rand %0d/%0d cand %0d/%0d want 0 0 50/0 50/0",
                     bus_b.valid, bus_b.busy, bus_b.rand_x, bus_b.rand_y, bus_b.cand_x, bus_b.cand_y);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus_b.valid !== 1'b0 || bus_b.busy !== 1'b0) begin
                errors++;
                $display("FAIL degen_abort cycle %0d v%b b%b want 0 0", i, bus_b.valid, bus_b.busy);
            end
        end
    endtask

    initial begin
        bus_a.req = 1'b0;
        bus_a.cand_hit = 1'b0;
        bus_b.req = 1'b0;
        bus_b.cand_hit = 1'b0;
        test_reset();
        test_latency();
        test_retry();
        test_exhaust();
        test_back_to_back();
        test_range_sweep();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
